sqrt2_host: RTL and testbench

Host-side bus master for the sqrt2 half-precision square-root unit. It takes operands from an upstream valid/ready stream and runs the sqrt2 transaction over the shared tri-state IO_DATA bus: drive the operand, release the bus, wait for RESULT, then capture the result and flags. Results and a timeout indication go out on a downstream valid/ready stream. It sits between the system datapath and one sqrt2 instance, and is the only other driver of IO_DATA.

---
 rtl/sqrt2_pkg.sv | 40 ++++
 rtl/sqrt2_host_if.sv | 34 +++
 rtl/sqrt2_host_rsp.sv | 46 ++++
 rtl/sqrt2_host.sv | 168 ++++++++++++++++
 tb/tb_sqrt2_host.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt2_pkg
//  Description : Shared types and constants for the sqrt2 host bus master.
//                Holds the FSM state encoding, binary16 special values, the
//                captured-response record and a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sqrt2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [15:0] FP16_QNAN = 16'hFE00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef struct packed {
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic        timeout;
  } rsp_t;

  // Largest of three counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt2_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt2_host_if
//  Description : System-side request/response streams of the sqrt2 host.
//                master : seen from sqrt2_host (accepts REQ, produces RSP)
//                slave  : seen from the system datapath
//  Ports       : REQ_VALID/REQ_READY/REQ_DATA[15:0]  operand stream
//                RSP_VALID/RSP_READY/RSP_DATA[15:0]  result stream
//                RSP_NAN/RSP_PINF/RSP_NINF/RSP_TIMEOUT result qualifiers
//  Revision    : 1.0 - initial release
// ============================================================================
interface sqrt2_host_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [15:0] REQ_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_DATA;
  logic        RSP_NAN;
  logic        RSP_PINF;
  logic        RSP_NINF;
  logic        RSP_TIMEOUT;

  modport master (
    input  REQ_VALID, REQ_DATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );

  modport slave (
    output REQ_VALID, REQ_DATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/sqrt2_host_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt2_host_rsp
//  Description : Response holding register with valid/ready handshake.
//                A load sets valid and captures the record; valid clears on
//                a handshake. Contents stay frozen while valid && !ready.
//  Ports       : clk, rst_n (async, active low)
//                i_load, i_data  capture strobe and record
//                i_ready         downstream ready
//                o_valid, o_data held response
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt2_host_rsp
  import sqrt2_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  input  rsp_t      i_data,
  input  wire logic i_ready,
  output logic      o_valid,
  output rsp_t      o_data
);

  logic r_valid;
  rsp_t r_data;

  // The FSM only loads when no response is pending, so load and consume
  // never coincide; load still takes priority for robustness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/sqrt2_host.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt2_host
//  Description : Host-side bus master for the sqrt2 half-precision square
//                root unit. Drives an operand onto the shared IO_DATA bus,
//                releases it, waits for RESULT (or times out), captures the
//                result and flags, and presents them on a response stream.
//  Ports       : CLK, RST_N (async, active low)
//                sys      sqrt2_host_if.master request/response streams
//                IO_DATA  shared tri-state bus to sqrt2
//                ENABLE   sqrt2 enable
//                IS_NAN/IS_PINF/IS_NINF, RESULT  status from sqrt2
//                BUSY     high whenever the FSM is not IDLE
//  Parameters  : LOAD_CYCLES (>=1) operand drive edges
//                TIMEOUT     WAIT edges without RESULT before abort
//                GAP_CYCLES  idle edges with ENABLE low between transactions
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt2_host
  import sqrt2_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 100,
  parameter int GAP_CYCLES  = 2
)(
  input  wire logic   CLK,
  input  wire logic   RST_N,
  sqrt2_host_if.master sys,
  inout  wire [15:0]  IO_DATA,
  output logic        ENABLE,
  input  wire logic   IS_NAN,
  input  wire logic   IS_PINF,
  input  wire logic   IS_NINF,
  input  wire logic   RESULT,
  output logic        BUSY
);

  localparam int c_cnt_w = $clog2(max3(TIMEOUT, LOAD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [c_cnt_w-1:0] c_load_last    = c_cnt_w'(LOAD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                 r_enable, w_enable_nxt;
  logic                 r_drive_en, w_drive_nxt;
  logic [15:0]          r_operand, w_operand_nxt;
  logic                 w_load;
  rsp_t                 w_load_data;
  logic                 w_rsp_valid;
  rsp_t                 w_rsp;
  logic                 w_req_ready;

  // Saturating increment: the counter never wraps.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Blocking new work while a response is pending keeps at most one
  // transaction outstanding and makes capture/consume mutually exclusive.
  assign w_req_ready = (r_state == IDLE) && !w_rsp_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_enable_nxt  = r_enable;
    w_drive_nxt   = r_drive_en;
    w_operand_nxt = r_operand;
    w_load        = 1'b0;
    w_load_data   = '0;
    case (r_state)
      IDLE: begin
        if (sys.REQ_VALID && w_req_ready) begin
          w_operand_nxt = sys.REQ_DATA;
          w_enable_nxt  = 1'b1;
          w_drive_nxt   = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = DRIVE;
        end
      end
      DRIVE: begin
        // RESULT is deliberately ignored here: the bus is still ours.
        if (r_cnt == c_load_last) begin
          w_drive_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT: begin
        if (RESULT) begin
          w_load      = 1'b1;
          w_load_data = '{data: IO_DATA, nan: IS_NAN, pinf: IS_PINF,
                          ninf: IS_NINF, timeout: 1'b0};
          w_state_nxt = HOLD;
        end else if (r_cnt == c_timeout_last) begin
          w_load      = 1'b1;
          w_load_data = '{data: FP16_ZERO, nan: 1'b0, pinf: 1'b0,
                          ninf: 1'b0, timeout: 1'b1};
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HOLD: begin
        // ENABLE has been high for exactly one edge past the capture.
        w_enable_nxt = 1'b0;
        w_cnt_nxt    = '0;
        w_state_nxt  = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_enable_nxt = 1'b0;
        w_drive_nxt  = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_enable   <= 1'b0;
      r_drive_en <= 1'b0;
      r_operand  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_enable   <= w_enable_nxt;
      r_drive_en <= w_drive_nxt;
      r_operand  <= w_operand_nxt;
    end
  end

  // The drive enable is an async-reset flop, so the bus is released the
  // moment RST_N falls.
  assign IO_DATA = r_drive_en ? r_operand : 16'hzzzz;
  assign ENABLE  = r_enable;
  assign BUSY    = (r_state != IDLE);

  sqrt2_host_rsp u_rsp (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_ready (sys.RSP_READY),
    .o_valid (w_rsp_valid),
    .o_data  (w_rsp)
  );

  assign sys.REQ_READY   = w_req_ready;
  assign sys.RSP_VALID   = w_rsp_valid;
  assign sys.RSP_DATA    = w_rsp.data;
  assign sys.RSP_NAN     = w_rsp.nan;
  assign sys.RSP_PINF    = w_rsp.pinf;
  assign sys.RSP_NINF    = w_rsp.ninf;
  assign sys.RSP_TIMEOUT = w_rsp.timeout;

endmodule
`default_nettype wire

// File: tb/tb_sqrt2_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sqrt2_host
//  Description : Self-checking bench for sqrt2_host with a behavioural sqrt2
//                stub (lookup table, programmable RESULT delay / never /
//                early-in-DRIVE modes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt2_host;

  localparam int L = 2;   // LOAD_CYCLES of the DUT

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt2_host_if sys_if ();
  wire  [15:0] io_data;
  logic        enable, busy, result, is_nan, is_pinf, is_ninf, m_drive;

  sqrt2_host #(.LOAD_CYCLES(L), .TIMEOUT(100), .GAP_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .sys(sys_if), .IO_DATA(io_data), .ENABLE(enable),
    .IS_NAN(is_nan), .IS_PINF(is_pinf), .IS_NINF(is_ninf), .RESULT(result),
    .BUSY(busy)
  );

  // ---------------- sqrt2 stub ----------------
  // m_mode: 0 = RESULT on the k-th WAIT edge, 1 = never, 2 = also pulse
  // RESULT (without driving the bus) during DRIVE.
  int          m_cnt, m_mode, m_k;
  logic [15:0] m_op;
  logic [18:0] m_ref;

  function automatic logic [18:0] sqrt_ref(input logic [15:0] op);
    case (op)
      16'h4400: return {16'h4000, 3'b000};
      16'hFC00: return {16'hFE00, 3'b100};
      16'h7C00: return {16'h7C00, 3'b010};
      16'h0001: return {16'h0C00, 3'b000};
      16'h3C00: return {16'h3C00, 3'b000};
      16'h5400: return {16'h4800, 3'b000};
      16'h4C00: return {16'h4400, 3'b000};
      16'h7E01: return {16'hFC00, 3'b001};  // stub-only code for IS_NINF path
      default:  return {16'hFE00, 3'b100};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_op  <= 16'h0;
    end else if (!enable) begin
      m_cnt <= 0;
    end else begin
      if (m_cnt == 0) m_op <= io_data;
      m_cnt <= m_cnt + 1;
    end
  end

  assign m_ref   = sqrt_ref(m_op);
  assign result  = enable && ((m_mode != 1 && m_cnt >= L + m_k - 1) ||
                              (m_mode == 2 && m_cnt == 1));
  assign m_drive = result && (m_cnt >= L);
  assign io_data = m_drive ? m_ref[18:3] : 16'hzzzz;
  assign is_nan  = result & m_ref[2];
  assign is_pinf = result & m_ref[1];
  assign is_ninf = result & m_ref[0];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present op; returns #1 after the accept edge. keep leaves REQ_VALID high.
  task automatic send(input logic [15:0] op, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    sys_if.REQ_VALID = 1'b1;
    sys_if.REQ_DATA  = op;
    while (!sys_if.REQ_READY && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL accept_timeout: got no REQ_READY expected REQ_READY within 500");
    end
    @(posedge clk);
    #1;
    if (!keep) sys_if.REQ_VALID = 1'b0;
  endtask

  // Called #1 after the accept edge; returns #1 after the RSP_VALID edge.
  task automatic wait_rsp(output int lat, output int drv);
    lat = 0;
    drv = dut.r_drive_en ? 1 : 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (dut.r_drive_en) drv++;
      if (!dut.r_drive_en && result && $isunknown(io_data)) begin
        errors++;
        $display("FAIL bus_x: got %0h expected known value", io_data);
      end
    end while (!sys_if.RSP_VALID && lat < 300);
  endtask

  function automatic logic [31:0] rsp_word();
    return {12'h0, sys_if.RSP_DATA, sys_if.RSP_NAN, sys_if.RSP_PINF,
            sys_if.RSP_NINF, sys_if.RSP_TIMEOUT};
  endfunction

  typedef struct {
    logic [15:0] op;
    int          mode;
    int          k;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;  // {nan, pinf, ninf, timeout}
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, drv, bad;
    vecs[0] = '{16'h4400, 0, 1, 16'h4000, 4'b0000, L + 1};
    vecs[1] = '{16'hFC00, 0, 2, 16'hFE00, 4'b1000, L + 2};
    vecs[2] = '{16'h7C00, 0, 3, 16'h7C00, 4'b0100, L + 3};
    vecs[3] = '{16'h0001, 0, 1, 16'h0C00, 4'b0000, L + 1};
    vecs[4] = '{16'h7E01, 0, 2, 16'hFC00, 4'b0010, L + 2};
    vecs[5] = '{16'h4400, 1, 1, 16'h0000, 4'b0001, L + 100};
    vecs[6] = '{16'h5400, 2, 3, 16'h4800, 4'b0000, L + 3};
    vecs[7] = '{16'h3C00, 0, 4, 16'h3C00, 4'b0000, L + 4};

    m_mode = 0;
    m_k    = 1;
    sys_if.REQ_VALID = 1'b0;
    sys_if.REQ_DATA  = 16'h0;
    sys_if.RSP_READY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_drive", dut.r_drive_en, 0);
    check("rst_rsp_valid", sys_if.RSP_VALID, 0);
    check("rst_rsp", rsp_word(), 0);
    check("rst_req_ready", sys_if.REQ_READY, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions
    foreach (vecs[i]) begin
      m_mode = vecs[i].mode;
      m_k    = vecs[i].k;
      send(vecs[i].op, 1'b0);
      wait_rsp(lat, drv);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rsp", i), rsp_word(), {12'h0, vecs[i].exp_data, vecs[i].exp_flags});
      check($sformatf("v%0d_drive_edges", i), drv, L);
      check($sformatf("v%0d_enable_hold", i), enable, 1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_enable_fall", i), enable, 0);
      check($sformatf("v%0d_rsp_consumed", i), sys_if.RSP_VALID, 0);
    end

    // Back-to-back with downstream backpressure
    m_mode = 0;
    m_k    = 1;
    sys_if.RSP_READY = 1'b0;
    send(16'h3C00, 1'b1);
    sys_if.REQ_DATA = 16'h5400;
    wait_rsp(lat, drv);
    check("b2b_first_latency", lat, L + 1);
    check("b2b_first_rsp", rsp_word(), {12'h0, 16'h3C00, 4'b0000});
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!sys_if.RSP_VALID || sys_if.RSP_DATA !== 16'h3C00 || sys_if.REQ_READY) bad++;
    end
    check("b2b_hold_stable", bad, 0);
    check("b2b_idle_not_busy", busy, 0);
    @(negedge clk);
    sys_if.RSP_READY = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_consumed", sys_if.RSP_VALID, 0);
    check("b2b_req_ready", sys_if.REQ_READY, 1);
    @(posedge clk);
    #1;
    sys_if.REQ_VALID = 1'b0;
    check("b2b_second_accept", busy, 1);
    wait_rsp(lat, drv);
    check("b2b_second_latency", lat, L + 1);
    check("b2b_second_rsp", rsp_word(), {12'h0, 16'h4800, 4'b0000});

    // Asynchronous reset during DRIVE
    send(16'h4C00, 1'b0);
    check("rstmid_in_drive", dut.r_drive_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_enable", enable, 0);
    check("rstmid_drive", dut.r_drive_en, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rsp_valid", sys_if.RSP_VALID, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (sys_if.RSP_VALID || enable) bad++;
    end
    check("rstmid_no_rsp", bad, 0);
    send(16'h4C00, 1'b0);
    wait_rsp(lat, drv);
    check("rstmid_next_latency", lat, L + 1);
    check("rstmid_next_rsp", rsp_word(), {12'h0, 16'h4400, 4'b0000});

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
